bus_master_8088: RTL and testbench

- Synthesizable 8088 minimum-mode bus initiator: converts a simple valid/ready request port into T1-T2-T3-(TW)-T4 bus cycles.
- Drives ALE, RD, WR, IOM, DTR, DEN, A[19:8] and AD[7:0] with the same pin semantics as the Intel8088Pins Processor modport.
- Memory and IO peripherals, the address latch and the 8286-style transceiver attach unchanged.
- Used as a test/DMA master in place of the processor model.

---
 rtl/bus_master_8088.sv | 153 +++++++++++++++
 tb/tb_bus_master_8088.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_8088.sv
// Purpose : 8088 minimum-mode bus initiator; turns valid/ready requests into T1-T2-T3-(TW)-T4 cycles.
// Latency : accept edge k -> rsp_valid during T4 (4th cycle after accept with no waits, +1 per TW).
// Backpr. : req_ready only in IDLE/T4; READY low inserts TW states, WAIT_MAX waits abort with rsp_err.
// Ports   : CLK/RESET (async, active-low); req_* request port; rsp_* one-cycle response;
//           READY, AD (tri-state), A[19:8], ALE, RD, WR, IOM, DTR, DEN 8088 pins (RD/WR/DEN active-low).
module bus_master_8088 #(
    parameter int WAIT_MAX = 15,
    parameter int WCNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        READY,
    inout  wire  [7:0]  AD,
    output logic [11:0] A,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        IOM,
    output logic        DTR,
    output logic        DEN
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

    localparam logic [WCNT_W-1:0] WAIT_LIM = WAIT_MAX[WCNT_W-1:0];
    localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              write_q;
    logic [7:0]        wdata_q;
    logic [7:0]        ad_out;
    logic              ad_oe;
    logic [WCNT_W-1:0] wcnt;
    logic              accept;
    logic              finish;
    logic              finish_err;

    // AD is only ever driven from registers; the pin is released whenever ad_oe is low.
    assign AD        = ad_oe ? ad_out : 8'hzz;
    assign req_ready = (state == S_IDLE) || (state == S_T4);
    assign accept    = req_valid && req_ready;

    // Decide whether the data phase ends at this edge (T3/TW only).
    always_comb begin
        finish     = 1'b0;
        finish_err = 1'b0;
        if (state == S_T3) begin
            if (READY) begin
                finish = 1'b1;
            end else if (WAIT_MAX == 0) begin
                finish     = 1'b1;
                finish_err = 1'b1;
            end
        end else if (state == S_TW) begin
            if (READY) begin
                finish = 1'b1;
            end else if (wcnt >= WAIT_LIM) begin
                finish     = 1'b1;
                finish_err = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            write_q   <= 1'b0;
            wdata_q   <= 8'h00;
            ad_out    <= 8'h00;
            ad_oe     <= 1'b0;
            wcnt      <= '0;
            A         <= 12'h000;
            ALE       <= 1'b0;
            RD        <= 1'b1;
            WR        <= 1'b1;
            DEN       <= 1'b1;
            DTR       <= 1'b0;
            IOM       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE, S_T4: begin
                    if (accept) begin
                        state   <= S_T1;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        ad_out  <= req_addr[7:0];
                        ad_oe   <= 1'b1;
                        A       <= req_addr[19:8];
                        IOM     <= req_io;
                        DTR     <= req_write;
                        ALE     <= 1'b1;
                        wcnt    <= '0;
                    end else begin
                        // Write data hold ends with T4; A/IOM/DTR simply stay put.
                        state <= S_IDLE;
                        ad_oe <= 1'b0;
                        ALE   <= 1'b0;
                    end
                end
                S_T1: begin
                    state <= S_T2;
                    ALE   <= 1'b0;
                    DEN   <= 1'b0;
                    if (write_q) begin
                        ad_out <= wdata_q;
                        ad_oe  <= 1'b1;
                        WR     <= 1'b0;
                    end else begin
                        ad_oe <= 1'b0;
                        RD    <= 1'b0;
                    end
                end
                S_T2: state <= S_T3;
                S_T3, S_TW: begin
                    if (finish) begin
                        state     <= S_T4;
                        RD        <= 1'b1;
                        WR        <= 1'b1;
                        DEN       <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= finish_err;
                        wcnt      <= '0;
                        if (finish_err) begin
                            rsp_rdata <= 8'hFF;
                        end else if (!write_q) begin
                            rsp_rdata <= AD;
                        end
                    end else if (state == S_T3) begin
                        state <= S_TW;
                        wcnt  <= WCNT_ONE;
                    end else begin
                        wcnt <= wcnt + WCNT_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_8088.sv
module tb_bus_master_8088;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        READY;
    wire  [7:0]  AD;
    logic [11:0] A;
    logic        ALE, RD, WR, IOM, DTR, DEN;
    logic [7:0]  periph_data;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t       sb[$];
    rsp_t       e;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_rdata = 8'h00;

    bus_master_8088 #(.WAIT_MAX(15), .WCNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .READY(READY), .AD(AD), .A(A),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .DTR(DTR), .DEN(DEN)
    );

    // Peripheral returns data while the read strobe is active.
    assign AD = (!RD) ? periph_data : 8'hzz;

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Drive a request, record the expected response, return in the T1 cycle.
    task automatic issue(input logic w, input logic io, input logic [19:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err);
        int n;
        rsp_t x;
        req_write = w; req_io = io; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout got req_ready=%b want 1", req_ready);
        end
        x.rdata = exp_rd; x.err = exp_err;
        sb.push_back(x);
        last_rdata = exp_rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; READY = 1'b1; periph_data = 8'h00;
        tick(); tick();
        checks++;
        if ({ALE, RD, WR, DEN, DTR, IOM, A, rsp_valid, rsp_rdata, rsp_err, req_ready}
            !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_pins got ALE%b RD%b WR%b DEN%b DTR%b IOM%b A%h v%b d%h e%b rdy%b want 0 1 1 1 0 0 000 0 00 0 1",
                     ALE, RD, WR, DEN, DTR, IOM, A, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        checks++;
        if (dut.ad_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_ad_release got ad_oe=%b want 0", dut.ad_oe);
        end
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_mem_read;
        int rc = 0;
        READY = 1'b1; periph_data = 8'hA5;
        issue(1'b0, 1'b0, 20'h01234, 8'h00, 8'hA5, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) begin
                checks++;
                if ({ALE, AD, A, IOM, DTR, RD, WR, DEN} !== {1'b1, 8'h34, 12'h012, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL rd_t1 got ALE%b AD%h A%h IOM%b DTR%b RD%b WR%b DEN%b want 1 34 012 0 0 1 1 1",
                             ALE, AD, A, IOM, DTR, RD, WR, DEN);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({ALE, RD, WR, DEN} !== 4'b0010) begin
                    errors++;
                    $display("FAIL rd_strobes c%0d got %b want 0010", c, {ALE, RD, WR, DEN});
                end
            end
            if (c == 5) begin
                checks++;
                if ({rsp_valid, req_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL rd_pulse_end got v%b rdy%b want 0 1", rsp_valid, req_ready);
                end
            end
            if (rsp_valid) begin
                rc = c;
                checks++;
                e = sb.pop_front();
                if ({rsp_rdata, rsp_err, RD} !== {e.rdata, e.err, 1'b1}) begin
                    errors++;
                    $display("FAIL rd_rsp got %h/%b RD%b want %h/%b RD1", rsp_rdata, rsp_err, RD, e.rdata, e.err);
                end
            end
            tick();
        end
        checks++;
        if (rc !== 4) begin
            errors++;
            $display("FAIL rd_latency got %0d want 4", rc);
        end
    endtask

    task automatic test_io_write;
        int rc = 0;
        READY = 1'b1; periph_data = 8'h00;
        issue(1'b1, 1'b1, 20'h0FF03, 8'h5C, last_rdata, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin
                checks++;
                if ({ALE, AD, A, IOM, DTR, RD, WR, DEN} !== {1'b1, 8'h03, 12'h0FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL wr_t1 got ALE%b AD%h A%h IOM%b DTR%b RD%b WR%b DEN%b want 1 03 0ff 1 1 1 1 1",
                             ALE, AD, A, IOM, DTR, RD, WR, DEN);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({ALE, AD, IOM, DTR, RD, WR, DEN} !== {1'b0, 8'h5C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL wr_data c%0d got ALE%b AD%h IOM%b DTR%b RD%b WR%b DEN%b want 0 5c 1 1 1 0 0",
                             c, ALE, AD, IOM, DTR, RD, WR, DEN);
                end
            end
            if (c == 4) begin
                checks++;
                if ({AD, RD, WR, DEN} !== {8'h5C, 1'b1, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL wr_t4_hold got AD%h RD%b WR%b DEN%b want 5c 1 1 1", AD, RD, WR, DEN);
                end
            end
            if (c == 5) begin
                checks++;
                if (dut.ad_oe !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_release got ad_oe=%b want 0", dut.ad_oe);
                end
            end
            if (rsp_valid) begin
                rc = c;
                checks++;
                e = sb.pop_front();
                if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL wr_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
            tick();
        end
        checks++;
        if (rc !== 4) begin
            errors++;
            $display("FAIL wr_latency got %0d want 4", rc);
        end
    endtask

    task automatic test_wait_states;
        int rc = 0;
        READY = 1'b1; periph_data = 8'h3C;
        issue(1'b0, 1'b0, 20'h42A10, 8'h00, 8'h3C, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            READY = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            if (c >= 4 && c <= 6) begin
                checks++;
                if ({RD, DEN, rsp_valid} !== 3'b000) begin
                    errors++;
                    $display("FAIL tw_hold c%0d got RD%b DEN%b v%b want 0 0 0", c, RD, DEN, rsp_valid);
                end
            end
            if (rsp_valid) begin
                rc = c;
                checks++;
                e = sb.pop_front();
                if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL tw_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
            tick();
        end
        READY = 1'b1;
        checks++;
        if (rc !== 7) begin
            errors++;
            $display("FAIL tw_latency got %0d want 7", rc);
        end
    endtask

    task automatic test_timeout;
        int rc = 0;
        READY = 1'b0; periph_data = 8'h77;
        issue(1'b0, 1'b0, 20'h00100, 8'h00, 8'hFF, 1'b1);
        for (int c = 1; c <= 25; c++) begin
            if (rsp_valid) begin
                rc = c;
                checks++;
                e = sb.pop_front();
                if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL to_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
            tick();
        end
        checks++;
        if (rc !== 19) begin
            errors++;
            $display("FAIL to_latency got %0d want 19", rc);
        end
        // Next request after a timeout behaves normally.
        rc = 0;
        READY = 1'b1; periph_data = 8'h96;
        issue(1'b0, 1'b0, 20'h00101, 8'h00, 8'h96, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            if (rsp_valid) begin
                rc = c;
                checks++;
                e = sb.pop_front();
                if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
                    errors++;
                    $display("FAIL to_next_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
            tick();
        end
        checks++;
        if (rc !== 4) begin
            errors++;
            $display("FAIL to_next_latency got %0d want 4", rc);
        end
    endtask

    task automatic test_back_to_back;
        int   n = 0;
        int   nrsp = 0;
        rsp_t x;
        READY = 1'b1; periph_data = 8'h11;
        req_write = 1'b0; req_io = 1'b0; req_addr = 20'h80000; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        x.rdata = 8'h11; x.err = 1'b0;
        sb.push_back(x);
        tick();
        req_addr = 20'h80001;
        for (int c = 1; c <= 9; c++) begin
            if (c == 5) begin
                req_valid = 1'b0;
                periph_data = 8'h22;
                checks++;
                if ({AD, A} !== {8'h01, 12'h800}) begin
                    errors++;
                    $display("FAIL b2b_addr2 got AD%h A%h want 01 800", AD, A);
                end
            end
            checks++;
            if (ALE !== ((c == 1 || c == 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL b2b_ale c%0d got %b want %b", c, ALE, (c == 1 || c == 5));
            end
            if (c == 4) begin
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_t4 got %b want 1", req_ready);
                end
                x.rdata = 8'h22; x.err = 1'b0;
                sb.push_back(x);
            end
            if (rsp_valid) begin
                checks++;
                e = sb.pop_front();
                if ({rsp_rdata, rsp_err} !== {e.rdata, e.err} || c != ((nrsp == 0) ? 4 : 8)) begin
                    errors++;
                    $display("FAIL b2b_rsp c%0d got %h/%b want %h/%b at c%0d", c, rsp_rdata, rsp_err,
                             e.rdata, e.err, (nrsp == 0) ? 4 : 8);
                end
                nrsp++;
            end
            tick();
        end
        last_rdata = 8'h22;
        checks++;
        if (nrsp !== 2) begin
            errors++;
            $display("FAIL b2b_count got %0d want 2", nrsp);
        end
    endtask

    task automatic test_reset_mid;
        READY = 1'b1;
        issue(1'b1, 1'b0, 20'h12345, 8'hC3, last_rdata, 1'b0);
        tick();
        checks++;
        if ({WR, DEN} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_t2 got WR%b DEN%b want 0 0", WR, DEN);
        end
        #2 RESET = 1'b0;
        #1;
        checks++;
        if ({ALE, RD, WR, DEN, IOM, DTR, A, rsp_valid, rsp_rdata, dut.ad_oe}
            !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_pins got ALE%b RD%b WR%b DEN%b IOM%b DTR%b A%h v%b d%h oe%b want 0 1 1 1 0 0 000 0 00 0",
                     ALE, RD, WR, DEN, IOM, DTR, A, rsp_valid, rsp_rdata, dut.ad_oe);
        end
        sb.delete();
        last_rdata = 8'h00;
        tick(); tick();
        RESET = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                errors++;
                $display("FAIL rst_mid_after c%0d got v%b rdy%b want 0 1", c, rsp_valid, req_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
